// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered hex value, per-slot dead-time,
// leading-zero blanking and a frame pulse; every output is registered.
module seven_seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int SEG_ACT_LOW  = 1,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic                    i_load,
  input  logic                    i_lz_en,
  input  logic                    i_blank,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [N_DIGITS-1:0]     o_dig,
  output logic                    o_frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic          SEG_INV   = (SEG_ACT_LOW != 0);
  localparam logic          DIG_INV   = (DIG_ACT_LOW != 0);

  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_idx;
  logic [4*N_DIGITS-1:0]  r_pend_val;
  logic [N_DIGITS-1:0]    r_pend_dp;
  logic                   r_pend_flag;
  logic [4*N_DIGITS-1:0]  r_disp_val;
  logic [N_DIGITS-1:0]    r_disp_dp;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [N_DIGITS-1:0]    r_dig;
  logic                   r_frame;

  logic                   w_slot_end;
  logic                   w_frame_end;
  logic [3:0]             w_nib;
  logic                   w_dp_bit;
  logic                   w_lz_blank;
  logic                   w_zero_acc;
  logic [6:0]             w_seg_hi;
  logic [N_DIGITS-1:0]    w_dig_hi;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  assign w_slot_end  = (r_presc == PRESC_MAX);
  assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

  // Select the current digit and decide whether it is a leading zero (scanned from the MS end).
  always_comb begin
    w_nib      = 4'h0;
    w_dp_bit   = 1'b0;
    w_lz_blank = 1'b0;
    w_zero_acc = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_acc = w_zero_acc & (r_disp_val[4*k +: 4] == 4'h0);
      if (IW'(k) == r_idx) begin
        w_nib      = r_disp_val[4*k +: 4];
        w_dp_bit   = r_disp_dp[k];
        w_lz_blank = i_lz_en && (k != 0) && w_zero_acc;
      end else begin
        w_lz_blank = w_lz_blank;
      end
    end
    if (w_lz_blank) begin
      w_seg_hi = 7'b0000000;
    end else begin
      w_seg_hi = hex_to_seg(w_nib);
    end
    if ((r_presc >= BLANK_END) && !i_blank) begin
      w_dig_hi = N_DIGITS'(1) << r_idx;
    end else begin
      w_dig_hi = '0;
    end
  end

  // Scan counters, double buffer and registered pin drivers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_seg       <= {7{SEG_INV}};
      r_dp        <= SEG_INV;
      r_dig       <= {N_DIGITS{DIG_INV}};
      r_frame     <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      // A load landing on the boundary bypasses the pending buffer.
      if (w_frame_end && i_load) begin
        r_disp_val  <= i_value;
        r_disp_dp   <= i_dp;
        r_pend_flag <= 1'b0;
      end else if (w_frame_end && r_pend_flag) begin
        r_disp_val  <= r_pend_val;
        r_disp_dp   <= r_pend_dp;
        r_pend_flag <= 1'b0;
      end else if (i_load) begin
        r_pend_val  <= i_value;
        r_pend_dp   <= i_dp;
        r_pend_flag <= 1'b1;
      end
      r_seg   <= w_seg_hi ^ {7{SEG_INV}};
      r_dp    <= w_dp_bit ^ SEG_INV;
      r_dig   <= w_dig_hi ^ {N_DIGITS{DIG_INV}};
      r_frame <= w_frame_end;
    end
  end

  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_dig   = r_dig;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: table vectors, corner sequences and a
// randomized run checked every cycle against a time-based behavioural model.
module tb_seven_seg_scan_driver;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic        odp;
  logic [3:0]  dig;
  logic        frame;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic [3:0]  m_disp_dp = 4'h0;
  logic [3:0]  m_pend_dp = 4'h0;
  bit          m_flag = 1'b0;

  typedef struct packed {
    logic [15:0] val;
    logic        lz;
    logic [27:0] exp;
  } vec_t;
  vec_t tbl [7];

  seven_seg_scan_driver #(
    .N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp(dp), .i_load(load),
    .i_lz_en(lz_en), .i_blank(blank), .o_seg(seg), .o_dp(odp), .o_dig(dig), .o_frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;  4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;  4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;  4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;  4'hE: s = 7'b1001111;  default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Expected {seg,dp,dig,frame} after the edge whose pre-edge cycle-of-run is cyc.
  function automatic logic [12:0] model_out();
    int          idx = (cyc / DIV) % N;
    int          ph = cyc % DIV;
    logic [15:0] upper = m_disp >> (idx * 4);
    logic [6:0]  s;
    logic [3:0]  d;
    s = (lz_en && idx > 0 && upper == 16'h0) ? 7'b0000000 : glyph(upper[3:0]);
    d = (ph >= BLK && !blank) ? (4'b0001 << idx) : 4'b0000;
    return {~s, ~m_disp_dp[idx], ~d, (cyc % FRAME) == FRAME - 1};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    logic [12:0] exp;
    load  = ld;
    value = v;
    dp    = d;
    exp   = model_out();
    if ((cyc % FRAME) == FRAME - 1) begin
      if (ld) begin
        m_disp = v; m_disp_dp = d; m_flag = 1'b0;
      end else if (m_flag) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_flag = 1'b0;
      end
    end else if (ld) begin
      m_pend = v; m_pend_dp = d; m_flag = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("model", {19'h0, seg, odp, dig, frame}, {19'h0, exp});
    cyc++;
    load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) idle();
  endtask

  task automatic model_reset();
    cyc = 0; m_disp = 16'h0; m_pend = 16'h0; m_disp_dp = 4'h0; m_pend_dp = 4'h0; m_flag = 1'b0;
  endtask

  initial begin
    logic [6:0] obs [4];
    int         pulses [$];
    int         hits;

    tbl[0] = '{16'h0007, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
    tbl[1] = '{16'h0007, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111}};
    tbl[2] = '{16'h1234, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    tbl[3] = '{16'hABCD, 1'b0, {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}};
    tbl[4] = '{16'hEF09, 1'b1, {7'b0110000, 7'b0111000, 7'b0000001, 7'b0000100}};
    tbl[5] = '{16'h0100, 1'b1, {7'b1111111, 7'b1001111, 7'b0000001, 7'b0000001}};
    tbl[6] = '{16'h5680, 1'b1, {7'b0100100, 7'b0100000, 7'b0000000, 7'b0000001}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {19'h0, seg, odp, dig, frame}, {19'h0, 7'h7F, 1'b1, 4'hF, 1'b0});
    rst_n = 1'b1;
    model_reset();

    // Load 0x1234 at the start of frame 0; it must only appear from frame 1.
    step(1'b1, 16'h1234, 4'h0);
    while (cyc < FRAME) idle();
    for (int i = 0; i < DIV; i++) begin
      idle();
      if (i < BLK) chk("t1_gap_dig", {28'h0, dig}, {28'h0, 4'b1111});
      else         chk("t1_dig0", {28'h0, dig}, {28'h0, 4'b1110});
      chk("t1_seg0", {25'h0, seg}, {25'h0, 7'b1001100});
    end

    // Frame cadence.
    wait_phase(0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      if (frame) pulses.push_back(cyc);
    end
    chk("t2_pulse_count", pulses.size(), 3);
    for (int i = 1; i < pulses.size(); i++) chk("t2_period", pulses[i] - pulses[i-1], FRAME);

    // Table of decode / leading-zero vectors.
    foreach (tbl[t]) begin
      lz_en = tbl[t].lz;
      wait_phase(($urandom_range(0, FRAME - 1)));
      step(1'b1, tbl[t].val, 4'($urandom));
      while ((cyc % FRAME) != 0) idle();
      for (int k = 0; k < N; k++) obs[k] = 7'h55;
      for (int i = 0; i < FRAME; i++) begin
        idle();
        for (int k = 0; k < N; k++) if (dig == ~(4'b0001 << k)) obs[k] = seg;
      end
      chk("table", {4'h0, obs[3], obs[2], obs[1], obs[0]}, {4'h0, tbl[t].exp});
    end
    lz_en = 1'b0;

    // Overwritten pending load never shows; boundary-cycle load shows in the new frame.
    wait_phase(5);
    step(1'b1, 16'hAAAA, 4'h0);
    wait_phase(20);
    step(1'b1, 16'h5555, 4'h0);
    hits = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      idle();
      if (seg == 7'b0001000) hits++;
    end
    chk("t4_no_tear", hits, 0);
    chk("t4_latest", {25'h0, seg}, {25'h0, 7'b0100100});
    wait_phase(FRAME - 1);
    step(1'b1, 16'h9999, 4'h0);
    for (int i = 0; i < BLK + 1; i++) idle();
    chk("t4_boundary_load", {21'h0, seg, dig}, {21'h0, 7'b0000100, 4'b1110});

    // Global blank across a frame boundary.
    wait_phase(20);
    blank = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (dig != 4'b1111) hits++;
    end
    blank = 1'b0;
    chk("t5_blank", hits, 0);

    // Reset in the middle of digit 2's slot.
    wait_phase(2 * DIV + 4);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_async", {19'h0, seg, odp, dig, frame}, {19'h0, 7'h7F, 1'b1, 4'hF, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < BLK + 1; i++) idle();
    chk("t6_restart", {21'h0, seg, dig}, {21'h0, 7'b0000001, 4'b1110});

    // Randomized traffic against the model.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) blank = ~blank;
      step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
